axi4_decerr_slave: RTL and testbench



---
 rtl/axi4_decerr_slave.sv | 252 +++++++++++++++++++++++++
 tb/tb_axi4_decerr_slave.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_decerr_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_decerr_slave
// Purpose  : Default AXI4 target for unmapped crossbar addresses. Every write
//            and read is completed with a DECERR (2'b11) response so that the
//            requesting master always sees a protocol-complete transaction.
//            The write and read paths are independent, and each path holds at
//            most one outstanding transaction.
// Ports    : XBAR_CLK / sysReset        - clock, synchronous active-high reset
//            SLAVE_AW* / SLAVE_W*       - write address/data (AWID, WLAST used)
//            SLAVE_B*                   - write response (DECERR, latched AWID)
//            SLAVE_AR*                  - read address (ARID, ARLEN used)
//            SLAVE_R*                   - read data (DECERR, latched ARID)
// Config   : AXI4_DECERR_SLAVE_RDATA_PATTERN_EN - when defined, RDATA carries
//            32'hDEADBEEF (replicated) during valid beats; otherwise it is 0.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_decerr_slave #(
    parameter int ID_WIDTH         = 16,
    parameter int ADDR_WIDTH       = 20,
    parameter int SLAVE_DATA_WIDTH = 32,
    parameter int USER_WIDTH       = 1
) (
    input  logic                          XBAR_CLK,
    input  logic                          sysReset,
    // write address
    input  logic [ID_WIDTH-1:0]           SLAVE_AWID,
    input  logic [ADDR_WIDTH-1:0]         SLAVE_AWADDR,
    input  logic [7:0]                    SLAVE_AWLEN,
    input  logic [2:0]                    SLAVE_AWSIZE,
    input  logic [1:0]                    SLAVE_AWBURST,
    input  logic [1:0]                    SLAVE_AWLOCK,
    input  logic [3:0]                    SLAVE_AWCACHE,
    input  logic [2:0]                    SLAVE_AWPROT,
    input  logic [3:0]                    SLAVE_AWREGION,
    input  logic [3:0]                    SLAVE_AWQOS,
    input  logic [USER_WIDTH-1:0]         SLAVE_AWUSER,
    input  logic                          SLAVE_AWVALID,
    output logic                          SLAVE_AWREADY,
    // write data
    input  logic [SLAVE_DATA_WIDTH-1:0]   SLAVE_WDATA,
    input  logic [SLAVE_DATA_WIDTH/8-1:0] SLAVE_WSTRB,
    input  logic                          SLAVE_WLAST,
    input  logic [USER_WIDTH-1:0]         SLAVE_WUSER,
    input  logic                          SLAVE_WVALID,
    output logic                          SLAVE_WREADY,
    // write response
    output logic [ID_WIDTH-1:0]           SLAVE_BID,
    output logic [1:0]                    SLAVE_BRESP,
    output logic [USER_WIDTH-1:0]         SLAVE_BUSER,
    output logic                          SLAVE_BVALID,
    input  logic                          SLAVE_BREADY,
    // read address
    input  logic [ID_WIDTH-1:0]           SLAVE_ARID,
    input  logic [ADDR_WIDTH-1:0]         SLAVE_ARADDR,
    input  logic [7:0]                    SLAVE_ARLEN,
    input  logic [2:0]                    SLAVE_ARSIZE,
    input  logic [1:0]                    SLAVE_ARBURST,
    input  logic [1:0]                    SLAVE_ARLOCK,
    input  logic [3:0]                    SLAVE_ARCACHE,
    input  logic [2:0]                    SLAVE_ARPROT,
    input  logic [3:0]                    SLAVE_ARREGION,
    input  logic [3:0]                    SLAVE_ARQOS,
    input  logic [USER_WIDTH-1:0]         SLAVE_ARUSER,
    input  logic                          SLAVE_ARVALID,
    output logic                          SLAVE_ARREADY,
    // read data
    output logic [ID_WIDTH-1:0]           SLAVE_RID,
    output logic [SLAVE_DATA_WIDTH-1:0]   SLAVE_RDATA,
    output logic [1:0]                    SLAVE_RRESP,
    output logic                          SLAVE_RLAST,
    output logic [USER_WIDTH-1:0]         SLAVE_RUSER,
    output logic                          SLAVE_RVALID,
    input  logic                          SLAVE_RREADY
);

    localparam logic [1:0] c_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wstate_t               r_wstate;
    wstate_t               w_wstate_next;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [ID_WIDTH-1:0]   r_bid;
    logic                  w_aw_hs;

    assign w_aw_hs = SLAVE_AWVALID && r_awready;

    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_next = W_DATA;
            // Data beats are discarded; WLAST alone closes the burst.
            W_DATA:  if (SLAVE_WVALID && r_wready && SLAVE_WLAST) w_wstate_next = W_RESP;
            W_RESP:  if (SLAVE_BREADY && r_bvalid) w_wstate_next = W_IDLE;
            default: w_wstate_next = W_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode so
    // they change exactly one edge after the event that caused them.
    always_ff @(posedge XBAR_CLK) begin
        if (sysReset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_bid     <= '0;
        end else begin
            r_wstate  <= w_wstate_next;
            r_awready <= (w_wstate_next == W_IDLE);
            r_wready  <= (w_wstate_next == W_DATA);
            r_bvalid  <= (w_wstate_next == W_RESP);
            r_bresp   <= (w_wstate_next == W_RESP) ? c_DECERR : 2'b00;
            if (w_aw_hs) begin
                r_bid <= SLAVE_AWID;
            end
        end
    end

    assign SLAVE_AWREADY = r_awready;
    assign SLAVE_WREADY  = r_wready;
    assign SLAVE_BVALID  = r_bvalid;
    assign SLAVE_BRESP   = r_bresp;
    assign SLAVE_BID     = r_bid;
    assign SLAVE_BUSER   = '0;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rstate_t               r_rstate;
    rstate_t               w_rstate_next;
    logic                  r_arready;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [1:0]            r_rresp;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic [7:0]            w_len_next;
    logic [7:0]            w_cnt_next;
    logic                  w_ar_hs;

    assign w_ar_hs = SLAVE_ARVALID && r_arready;

    always_comb begin
        w_rstate_next = r_rstate;
        w_cnt_next    = r_cnt;
        w_len_next    = r_len;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rstate_next = R_DATA;
                    w_cnt_next    = 8'd0;
                    w_len_next    = SLAVE_ARLEN;
                end
            end
            R_DATA: begin
                if (SLAVE_RREADY && r_rvalid) begin
                    // The counter stops at ARLEN, so ARLEN=255 never wraps.
                    if (r_rlast) begin
                        w_rstate_next = R_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge XBAR_CLK) begin
        if (sysReset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= 2'b00;
            r_rid     <= '0;
            r_len     <= 8'd0;
            r_cnt     <= 8'd0;
        end else begin
            r_rstate  <= w_rstate_next;
            r_arready <= (w_rstate_next == R_IDLE);
            r_rvalid  <= (w_rstate_next == R_DATA);
            // RLAST is precomputed for the beat about to be presented.
            r_rlast   <= (w_rstate_next == R_DATA) && (w_cnt_next == w_len_next);
            r_rresp   <= (w_rstate_next == R_DATA) ? c_DECERR : 2'b00;
            r_len     <= w_len_next;
            r_cnt     <= w_cnt_next;
            if (w_ar_hs) begin
                r_rid <= SLAVE_ARID;
            end
        end
    end

    assign SLAVE_ARREADY = r_arready;
    assign SLAVE_RVALID  = r_rvalid;
    assign SLAVE_RLAST   = r_rlast;
    assign SLAVE_RRESP   = r_rresp;
    assign SLAVE_RID     = r_rid;
    assign SLAVE_RUSER   = '0;

`ifdef AXI4_DECERR_SLAVE_RDATA_PATTERN_EN
    // Replicate the marker word and trim, so widths that are not a multiple
    // of 32 still get a well-defined pattern.
    localparam int c_REPS = (SLAVE_DATA_WIDTH + 31) / 32;
    localparam logic [c_REPS*32-1:0] c_PATTERN_FULL = {c_REPS{32'hDEAD_BEEF}};
    localparam logic [SLAVE_DATA_WIDTH-1:0] c_PATTERN = c_PATTERN_FULL[SLAVE_DATA_WIDTH-1:0];

    logic [SLAVE_DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge XBAR_CLK) begin
        if (sysReset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= (w_rstate_next == R_DATA) ? c_PATTERN : '0;
        end
    end

    assign SLAVE_RDATA = r_rdata;
`else
    assign SLAVE_RDATA = '0;
`endif

    // Address attributes and write payload are accepted but never used.
    logic w_unused;
    assign w_unused = ^{SLAVE_AWADDR, SLAVE_AWLEN, SLAVE_AWSIZE, SLAVE_AWBURST,
                        SLAVE_AWLOCK, SLAVE_AWCACHE, SLAVE_AWPROT, SLAVE_AWREGION,
                        SLAVE_AWQOS, SLAVE_AWUSER, SLAVE_WDATA, SLAVE_WSTRB,
                        SLAVE_WUSER, SLAVE_ARADDR, SLAVE_ARSIZE, SLAVE_ARBURST,
                        SLAVE_ARLOCK, SLAVE_ARCACHE, SLAVE_ARPROT, SLAVE_ARREGION,
                        SLAVE_ARQOS, SLAVE_ARUSER};

endmodule
`default_nettype wire

// File: tb/tb_axi4_decerr_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_decerr_slave
// Purpose  : Directed self-checking bench for axi4_decerr_slave. Inputs are
//            driven 1 ns after each rising edge and outputs are checked at the
//            same point, so every check sees the registered state produced by
//            the preceding edge.
// Config   : honours AXI4_DECERR_SLAVE_RDATA_PATTERN_EN for RDATA expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_decerr_slave;

    localparam int ID_WIDTH   = 16;
    localparam int ADDR_WIDTH = 20;
    localparam int DW         = 32;
    localparam int USER_WIDTH = 1;

`ifdef AXI4_DECERR_SLAVE_RDATA_PATTERN_EN
    localparam logic [DW-1:0] c_RDATA_BEAT = 32'hDEAD_BEEF;
`else
    localparam logic [DW-1:0] c_RDATA_BEAT = 32'h0000_0000;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;

    logic [ID_WIDTH-1:0]   awid = '0;
    logic [7:0]            awlen = '0;
    logic                  awvalid = 1'b0;
    logic                  wlast = 1'b0;
    logic                  wvalid = 1'b0;
    logic                  bready = 1'b0;
    logic [ID_WIDTH-1:0]   arid = '0;
    logic [7:0]            arlen = '0;
    logic                  arvalid = 1'b0;
    logic                  rready = 1'b0;

    logic                  awready, wready, bvalid, arready, rvalid, rlast;
    logic [ID_WIDTH-1:0]   bid, rid;
    logic [1:0]            bresp, rresp;
    logic [USER_WIDTH-1:0] buser, ruser;
    logic [DW-1:0]         rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi4_decerr_slave #(
        .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .SLAVE_DATA_WIDTH(DW), .USER_WIDTH(USER_WIDTH)
    ) dut (
        .XBAR_CLK(clk), .sysReset(rst),
        .SLAVE_AWID(awid), .SLAVE_AWADDR('0), .SLAVE_AWLEN(awlen), .SLAVE_AWSIZE(3'd2),
        .SLAVE_AWBURST(2'b01), .SLAVE_AWLOCK(2'b00), .SLAVE_AWCACHE(4'd0), .SLAVE_AWPROT(3'd0),
        .SLAVE_AWREGION(4'd0), .SLAVE_AWQOS(4'd0), .SLAVE_AWUSER('0),
        .SLAVE_AWVALID(awvalid), .SLAVE_AWREADY(awready),
        .SLAVE_WDATA(32'h1357_9BDF), .SLAVE_WSTRB(4'hF), .SLAVE_WLAST(wlast), .SLAVE_WUSER('0),
        .SLAVE_WVALID(wvalid), .SLAVE_WREADY(wready),
        .SLAVE_BID(bid), .SLAVE_BRESP(bresp), .SLAVE_BUSER(buser),
        .SLAVE_BVALID(bvalid), .SLAVE_BREADY(bready),
        .SLAVE_ARID(arid), .SLAVE_ARADDR('0), .SLAVE_ARLEN(arlen), .SLAVE_ARSIZE(3'd2),
        .SLAVE_ARBURST(2'b01), .SLAVE_ARLOCK(2'b00), .SLAVE_ARCACHE(4'd0), .SLAVE_ARPROT(3'd0),
        .SLAVE_ARREGION(4'd0), .SLAVE_ARQOS(4'd0), .SLAVE_ARUSER('0),
        .SLAVE_ARVALID(arvalid), .SLAVE_ARREADY(arready),
        .SLAVE_RID(rid), .SLAVE_RDATA(rdata), .SLAVE_RRESP(rresp), .SLAVE_RLAST(rlast),
        .SLAVE_RUSER(ruser), .SLAVE_RVALID(rvalid), .SLAVE_RREADY(rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int beats;
        int lasts;

        // ---------------- reset ----------------
        tick(); tick(); tick();
        check("rst_awready", awready, 0);
        check("rst_wready",  wready,  0);
        check("rst_bvalid",  bvalid,  0);
        check("rst_arready", arready, 0);
        check("rst_rvalid",  rvalid,  0);
        check("rst_rlast",   rlast,   0);
        check("rst_bid",     bid,     0);
        check("rst_rid",     rid,     0);
        check("rst_bresp",   bresp,   0);
        check("rst_rresp",   rresp,   0);
        check("rst_rdata",   rdata,   0);
        rst = 1'b0;
        tick();
        check("idle_awready", awready, 1);
        check("idle_arready", arready, 1);
        check("idle_bvalid",  bvalid,  0);
        check("idle_rvalid",  rvalid,  0);

        // ---------------- 4-beat write ----------------
        awid = 16'h00A5; awlen = 8'd3; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wr_awready_low", awready, 0);
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            wvalid = 1'b1; wlast = (i == 3);
            check("wr_wready_beat", wready, 1);
            check("wr_no_b_yet",    bvalid, 0);
            if (wready) beats++;
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("wr_hs_count", beats, 4);
        check("wr_wready_after", wready, 0);
        check("wr_bvalid", bvalid, 1);
        check("wr_bid",    bid,    16'h00A5);
        check("wr_bresp",  bresp,  2'b11);
        check("wr_buser",  buser,  0);
        tick();     // BREADY low: response must hold
        check("wr_b_hold_valid", bvalid, 1);
        check("wr_b_hold_id",    bid,    16'h00A5);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("wr_b_done",  bvalid,  0);
        check("wr_aw_back", awready, 1);

        // ---------------- 8-beat read, RREADY toggling ----------------
        arid = 16'h1234; arlen = 8'd7; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        beats = 0;
        for (int cyc = 0; cyc < 40 && beats < 8; cyc++) begin
            rready = ((cyc % 2) == 0);
            check("rd8_rvalid",  rvalid,  1);
            check("rd8_arready", arready, 0);
            check("rd8_rid",     rid,     16'h1234);
            check("rd8_rresp",   rresp,   2'b11);
            check("rd8_rdata",   rdata,   c_RDATA_BEAT);
            check("rd8_rlast",   rlast,   (beats == 7));
            if (rvalid && rready) beats++;
            tick();
        end
        rready = 1'b0;
        check("rd8_beats",   beats,   8);
        check("rd8_end_rvalid", rvalid, 0);
        check("rd8_arready", arready, 1);

        // ---------------- 256-beat read ----------------
        arid = 16'h0BEE; arlen = 8'd255; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rready  = 1'b1;
        beats = 0; lasts = 0;
        for (int cyc = 0; cyc < 300 && beats < 256; cyc++) begin
            check("rd256_rvalid",  rvalid,  1);
            check("rd256_arready", arready, 0);
            check("rd256_rlast",   rlast,   (beats == 255));
            if (rlast) lasts++;
            if (rvalid) beats++;
            tick();
        end
        rready = 1'b0;
        check("rd256_beats",  beats,   256);
        check("rd256_lasts",  lasts,   1);
        check("rd256_arready", arready, 1);
        check("rd256_rvalid_end", rvalid, 0);

        // ---------------- early W, concurrent 1-beat read ----------------
        wvalid = 1'b1; wlast = 1'b1;
        arid = 16'h0042; arlen = 8'd0; arvalid = 1'b1;
        check("early_w_c0", wready, 0);
        tick();
        arvalid = 1'b0; rready = 1'b1;
        check("early_w_c1", wready, 0);
        check("cc_rvalid",  rvalid, 1);
        check("cc_rlast",   rlast,  1);
        check("cc_rid",     rid,    16'h0042);
        tick();
        rready = 1'b0;
        check("early_w_c2", wready, 0);
        check("cc_rdone",   rvalid, 0);
        check("cc_arready", arready, 1);
        tick();
        awid = 16'h0077; awvalid = 1'b1;
        check("early_w_c3", wready, 0);
        check("early_aw_rdy", awready, 1);
        tick();
        awvalid = 1'b0;
        check("early_w_open", wready, 1);
        check("early_no_b",   bvalid, 0);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        check("early_bvalid", bvalid, 1);
        check("early_bid",    bid,    16'h0077);
        check("early_wclose", wready, 0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("early_bdone", bvalid, 0);

        // ---------------- reset during read beat 2 ----------------
        arid = 16'h0005; arlen = 8'd5; arvalid = 1'b1;
        tick();
        arvalid = 1'b0; rready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            check("rr_rvalid", rvalid, 1);
            check("rr_rdata",  rdata,  c_RDATA_BEAT);
            tick();
        end
        check("rr_beat2_valid", rvalid, 1);
        check("rr_beat2_rdata", rdata,  c_RDATA_BEAT);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_abort_rvalid",  rvalid,  0);
        check("rr_abort_arready", arready, 0);
        check("rr_abort_rid",     rid,     0);
        tick();
        check("rr_release_arready", arready, 1);
        check("rr_release_rvalid",  rvalid,  0);
        tick();
        check("rr_quiet_rvalid", rvalid, 0);
        check("rr_quiet_bvalid", bvalid, 0);
        rready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
